// File: rtl/bit_serializer_piso.sv
// Parallel-in/serial-out word serializer, MSB first, with a one-word pending buffer for gapless streaming.
// Optional feature macro PISO_PARITY_EN: appends an even-parity bit after each word's LSB.
`timescale 1ns/1ps

module bit_serializer_piso #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             bit_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             word_done
);

`ifdef PISO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pend;
  logic             r_pend_v;
  logic [FRAME-1:0] r_shreg;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_word_done;

  logic             w_xfer;
  logic [FRAME-1:0] w_frame;

  // Frame image loaded into the shifter; the parity bit is taken from the word at load time.
`ifdef PISO_PARITY_EN
  assign w_frame = {r_pend, ^r_pend};
`else
  assign w_frame = r_pend;
`endif

  assign din_ready = rst & ~r_pend_v;
  assign w_xfer    = din_valid & din_ready;
  assign ser_valid = rst & (r_state == SHIFT);
  assign ser_out   = ser_valid & r_shreg[FRAME-1];
  assign busy      = rst & ((r_state == SHIFT) | r_pend_v);
  assign word_done = r_word_done;

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: r_pend is data qualified by r_pend_v, so it is deliberately left out of reset.
      r_state     <= IDLE;
      r_pend_v    <= 1'b0;
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_word_done <= 1'b0;
    end else begin
      r_word_done <= 1'b0;
      // A transfer only happens with r_pend_v low, so it never collides with a load below.
      if (w_xfer) begin
        r_pend   <= din;
        r_pend_v <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (r_pend_v) begin
            r_shreg   <= w_frame;
            r_pend_v  <= 1'b0;
            r_bit_cnt <= LAST_IDX;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_en) begin
            if (r_bit_cnt != '0) begin
              r_shreg   <= r_shreg << 1;
              r_bit_cnt <= r_bit_cnt - CW'(1);
            end else begin
              r_word_done <= 1'b1;
              if (r_pend_v) begin
                r_shreg   <= w_frame;
                r_pend_v  <= 1'b0;
                r_bit_cnt <= LAST_IDX;
              end else begin
                r_state <= IDLE;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/bit_serializer_piso.md
Name: bit_serializer_piso

Overview:
Parallel-in/serial-out stage directly upstream of the 1010 sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and drives them MSB-first onto a single-bit stream. Its `ser_out` connects straight to the detector's `in` port. A one-word pending buffer allows gapless back-to-back streaming, and a `bit_en` strobe throttles the shift rate.

Parameters:
WIDTH, 8, data word width in bits; legal range 2..32.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  reset; synchronous, active-low
din  input  WIDTH  parallel word to serialize
din_valid  input  1  din holds a valid word
din_ready  output  1  block can accept a word this cycle
bit_en  input  1  shift strobe; tie high for 1 bit/clk
ser_out  output  1  serial data bit; feeds detector `in`
ser_valid  output  1  ser_out carries a live bit
busy  output  1  shifting, or a word is pending
word_done  output  1  1-cycle pulse after a word's final bit is consumed

Behaviour:
- Registers: `pend` (WIDTH), `pend_v`, `shreg` (WIDTH), `bit_cnt` (clog2 of WIDTH+1), `state` (IDLE/SHIFT), `word_done`.
- Reset (rst==0 at an edge):
  - `pend_v`=0, `shreg`=0, `bit_cnt`=0, `state`=IDLE, `word_done`=0.
  - `din_ready` is forced 0 while rst is low.
  - `ser_out`, `ser_valid` and `busy` read 0.
  - Reset mid-word discards the in-flight word and the pending word. No `word_done` is issued.
- Handshake:
  - `din_ready` = rst & ~pend_v (combinational).
  - Transfer occurs on an edge where din_valid & din_ready: `pend`<=din, `pend_v`<=1.
  - `din` is don't-care when `din_valid` is low.
  - `din_valid` may deassert without a transfer.
- IDLE:
  - If `pend_v`: `shreg`<=`pend`, `pend_v`<=0, `bit_cnt`<=WIDTH-1, go to SHIFT.
  - A new transfer cannot coincide with this load, since `din_ready` is 0.
- SHIFT:
  - `ser_valid`=1 and `ser_out`=`shreg`[WIDTH-1].
  - On an edge with bit_en=1 and bit_cnt!=0: `shreg`<=`shreg`<<1, `bit_cnt`-1.
  - With bit_en=0 the state holds and the current bit stays on `ser_out`.
  - Last bit (bit_cnt==0, bit_en=1): `word_done`<=1 for the next cycle.
    - If `pend_v`: reload `shreg` from `pend`, `pend_v`<=0, `bit_cnt`<=WIDTH-1, stay in SHIFT. This gives a gapless stream.
    - Else: go to IDLE.
  - A transfer may occur in the same cycle as the last-bit reload only if `pend_v` was 0 at that cycle's start. In that case the new word becomes pending the same edge, and the reload does not happen.
- Outputs in IDLE: `ser_out`=0, `ser_valid`=0.
- `busy` = (state==SHIFT) | pend_v.
- Latency with `bit_en`=1:
  - Accept edge N.
  - Load edge N+1; first bit visible after N+1.
  - Last bit after edge N+WIDTH.
  - `word_done` high during the cycle following edge N+WIDTH+1.
- Sustained throughput: 1 bit per `bit_en` cycle while the upstream keeps `pend` filled.

Optional Feature:
PISO_PARITY_EN:
- Defined: after the LSB of each word, one extra bit is shifted. This bit is the even parity (XOR) of the word, captured at load.
  - `ser_valid` stays 1 for it.
  - `bit_cnt` loads WIDTH instead of WIDTH-1.
  - `word_done` and the reload/IDLE decision occur on the parity bit.
  - Frame = WIDTH+1 bits.
- Undefined: frame = WIDTH bits exactly as above. No parity logic is present.

Test Plan:
1. Hold rst=0 for 3 cycles with din_valid=1 -> din_ready=0, ser_valid=0, ser_out=0, busy=0. Release -> din_ready=1.
2. WIDTH=8, bit_en=1, single word 8'hA5:
   - ser_out = 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 2 cycles after accept.
   - word_done pulses once, then IDLE with ser_valid=0.
3. Back-to-back 8'hAA then 8'h55, din_valid held:
   - Second transfer accepted while the first shifts.
   - 16 contiguous valid bits 1010101001010101 with no ser_valid gap; word_done pulses twice.
   - Detector downstream asserts q on each 1010 occurrence.
4. bit_en high 1 cycle in 3, word 8'hC3:
   - Each bit is held 3 cycles; sequence 11000011 is preserved.
   - din_ready stays 0 while a second word is pending.
5. rst=0 asserted mid-word (after 4 bits) with a word pending:
   - Next cycle ser_valid=0, busy=0, no word_done.
   - After release, a new word 8'h0F serializes cleanly.
6. PISO_PARITY_EN defined:
   - 8'hA5 -> 9 bits ending in parity 0.
   - 8'h01 -> 9 bits ending in parity 1.
   - word_done follows the 9th bit.
